multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control FSM for the multicycle datapath. It sits directly upstream of CONDLOGIC.
//  Decodes Op/Funct/Rd and sequences FETCH->DECODE->execute->writeback.
//  Drives the datapath muxes and produces the PCS/RegW/MemW/FlagW/ALUControl inputs that CONDLOGIC gates with CondEx.
//  Stalls on memory via a mem_ready handshake and counts retired instructions.
// PARAMETERS
//  CNT_W          32  width of instr_count (wraps modulo 2**CNT_W)
//  USE_MEM_READY  1   0: mem_ready ignored, treated as constant 1
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  reset       in   1      asynchronous, active-low (0 = reset asserted)
//  Op          in   2      instr[27:26]; stable from DECODE until return to FETCH
//  Funct       in   6      instr[25:20]; Funct[5]=I, Funct[0]=S/L
//  Rd          in   4      instr[15:12]
//  mem_ready   in   1      memory access completes this cycle
//  IRWrite     out  1      load instruction register
//  NextPC      out  1      PC update from fetch increment
//  AdrSrc      out  1      0: PC, 1: ALU result as memory address
//  ALUSrcA     out  1      0: RegA, 1: PC
//  ALUSrcB     out  2      00 reg, 01 ExtImm, 10 const 4
//  ResultSrc   out  2      00 ALUOut, 01 Data, 10 ALUResult
//  ALUControl  out  2      00 ADD, 01 SUB, 10 AND, 11 ORR
//  FlagW       out  2      to CONDLOGIC: [1]=NZ write, [0]=CV write
//  PCS         out  1      to CONDLOGIC: Branch | (RegW & Rd==4'hF)
//  RegW        out  1      to CONDLOGIC: register write request
//  MemW        out  1      to CONDLOGIC: memory write request
//  illegal_op  out  1      one-cycle pulse in UNKNOWN state
//  instr_done  out  1      one-cycle pulse on the last cycle of each instruction
//  instr_count out  CNT_W  retired-instruction counter
// BEHAVIOUR
//  States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9 UNKNOWN=15.
//  Reset (async, reset==0): state=FETCH, instr_count=0.
//   Outputs then take FETCH values; RegW, MemW and PCS are 0. IRWrite and NextPC equal mem_ready.
//  Reset mid-instruction aborts it immediately: no further RegW/MemW, instr_count not incremented.
//  Transitions:
//   FETCH->DECODE if mem_ready, else hold.
//   DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECR; Op=00 & Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
//   MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
//   MEMRD -> MEMWB if mem_ready, else hold. MEMWR -> FETCH if mem_ready, else hold.
//   EXECR/EXECI -> ALUWB.
//   MEMWB, ALUWB, BRANCH, UNKNOWN -> FETCH.
//  Moore outputs; anything not listed is 0:
//   FETCH:  ALUSrcA=1 ALUSrcB=10 ResultSrc=10 IRWrite=NextPC=mem_ready
//   DECODE: ALUSrcA=1 ALUSrcB=10 ResultSrc=10
//   MEMADR: ALUSrcB=01
//   MEMRD:  AdrSrc=1
//   MEMWB:  ResultSrc=01 RegW=1
//   MEMWR:  AdrSrc=1 MemW=1 (held for every wait cycle)
//   EXECR:  ALUSrcB=00 ALUOp=1
//   EXECI:  ALUSrcB=01 ALUOp=1
//   ALUWB:  RegW=1
//   BRANCH: ALUSrcB=01 ResultSrc=10 Branch=1
//   UNKNOWN: illegal_op=1
//  ALU decode (combinational, internal ALUOp):
//   ALUOp=0 -> ALUControl=00, FlagW=00.
//   ALUOp=1, Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11, other->00.
//   FlagW[1]=ALUOp & Funct[0]; FlagW[0]=ALUOp & Funct[0] & (ALUControl==00 | ALUControl==01).
//  instr_done=1 on the final cycle: MEMWB, ALUWB, BRANCH, UNKNOWN, or MEMWR with mem_ready=1.
//  instr_count increments on the posedge ending that cycle and wraps to 0 past all-ones.
//  mem_ready is ignored in states that make no memory access.
// TESTING
//  ADD r3 (Op=00 Funct=001000 Rd=3), mem_ready=1
//   -> FETCH,DECODE,EXECR,ALUWB; RegW=1 only in ALUWB; ALUControl=00, FlagW=00; count 0->1.
//  SUBS (Funct=000101) -> FlagW=11 and ALUControl=01 in EXECR; ANDS (Funct=000001) -> FlagW=10.
//  LDR (Op=01 Funct[0]=1), mem_ready low 2 cycles in MEMRD
//   -> MEMRD held 3 cycles, AdrSrc=1 throughout; then MEMWB with ResultSrc=01, RegW=1.
//  STR (Funct[0]=0), mem_ready low 1 cycle
//   -> MemW=1 for 2 MEMWR cycles, instr_done only on the 2nd; ADD with Rd=15 -> PCS=1 in ALUWB.
//  B (Op=10) -> BRANCH with PCS=1, RegW=0; Op=11 -> illegal_op pulses 1 cycle, then FETCH.
//  reset=0 during MEMWR -> MemW=0 the same cycle, state=FETCH, count=0; CNT_W=4, 16 ADDs -> count wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle datapath: FETCH/DECODE/execute/writeback sequencing,
// datapath mux selects, ALU decode and a retired-instruction counter. Stalls only on mem_ready.
module multicycle_ctrl_fsm #(
  parameter int CNT_W         = 32,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUControl,
  output logic [1:0]       FlagW,
  output logic             PCS,
  output logic             RegW,
  output logic             MemW,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR   = 4'd6;
  localparam logic [3:0] S_EXECI   = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_UNKNOWN = 4'd15;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_mem_rdy;
  logic             w_alu_op;
  logic             w_branch;

  assign w_mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_mem_rdy) w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_mem_rdy) w_next = S_MEMWB;
      S_MEMWR:  if (w_mem_rdy) w_next = S_FETCH;
      S_EXECR,
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    RegW       = 1'b0;
    MemW       = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    w_alu_op   = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = w_mem_rdy;
        NextPC    = w_mem_rdy;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegW       = 1'b1;
        instr_done = 1'b1;
      end
      // MemW stays up through every wait cycle; the access retires with mem_ready
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        MemW       = 1'b1;
        instr_done = w_mem_rdy;
      end
      S_EXECR: w_alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB  = 2'b01;
        w_alu_op = 1'b1;
      end
      S_ALUWB: begin
        RegW       = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        w_branch   = 1'b1;
        instr_done = 1'b1;
      end
      S_UNKNOWN: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    if (w_alu_op) begin
      case (Funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
    end
  end

  // C/V only meaningful for the arithmetic ops (ADD/SUB)
  assign FlagW[1] = w_alu_op & Funct[0];
  assign FlagW[0] = w_alu_op & Funct[0] & ~ALUControl[1];
  assign PCS      = w_branch | (RegW & (Rd == 4'hF));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (instr_done) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign instr_count = r_count;

endmodule
